mp_link_tx: RTL and testbench

Multiplayer link transmitter: serialises this board's game state (score, ammo, pause, reload) onto a single UART-style wire towards the second board. Sits in the control section beside the score, ammo, pause and reload controllers, and is the sending end of the player-2 state link. Packets are requested once per video frame (`new_frame`). Each packet carries a sync byte, a checksum and a rolling sequence number.

---
 rtl/mp_link_tx_if.sv | 16 +
 rtl/mp_link_tx.sv | 119 +++++++++++
 tb/tb_mp_link_tx.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp_link_tx_if.sv
// Player-2 link transmitter handshake: game-state inputs and serial-line outputs.
interface mp_link_tx_if;
  logic       send;
  logic [3:0] score;
  logic [3:0] ammo;
  logic       pause;
  logic       reload;
  logic       tx;
  logic       busy;
  logic       frame_sent;

  modport master (output send, score, ammo, pause, reload,
                  input  tx, busy, frame_sent);
  modport slave  (input  send, score, ammo, pause, reload,
                  output tx, busy, frame_sent);
endinterface

// File: rtl/mp_link_tx.sv
// Multiplayer link transmitter: 4-byte 8N1 packet (sync, {score,ammo},
// {pause,reload,00,seq}, xor checksum) once per request, requests coalesced.
module mp_link_tx #(
  parameter int CLK_HZ = 65_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic           clk,
  input  logic           rst,
  mp_link_tx_if.slave    lnk
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [3:0]      seq;
  logic [3:0]      snap_score, snap_ammo, snap_seq;
  logic            snap_pause, snap_rel;
  logic            reload_flag, pending;
  logic            tick, req, last_stop, pkt_start;
  logic [2:0]      bit_nxt;
  logic [7:0]      b1, b2, cur_byte;
  logic            tx_d, busy_d, fs_d;

  assign tick      = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign req       = lnk.send | pending;
  assign last_stop = (state == STOP) && tick && (byte_idx == 2'd3);
  // a chained packet starts on the final stop tick so no idle bit is inserted
  assign pkt_start = ((state == IDLE) && req) || (last_stop && req);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // next-state: every non-idle transition happens on a bit-period tick
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (req) state_d = START;
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_d = STOP;
      STOP:  if (tick) state_d = (byte_idx != 2'd3 || req) ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output decode: line level, busy and done pulse for the coming cycle
  always_comb begin
    b1      = {snap_score, snap_ammo};
    b2      = {snap_pause, snap_rel, 2'b00, snap_seq};
    bit_nxt = (state == DATA && tick) ? bit_idx + 3'd1 : bit_idx;
    case (byte_idx)
      2'd0:    cur_byte = SYNC;
      2'd1:    cur_byte = b1;
      2'd2:    cur_byte = b2;
      default: cur_byte = SYNC ^ b1 ^ b2;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_nxt];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    fs_d   = last_stop;
  end

  // registered outputs; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lnk.tx         <= 1'b1;
      lnk.busy       <= 1'b0;
      lnk.frame_sent <= 1'b0;
    end else begin
      lnk.tx         <= tx_d;
      lnk.busy       <= busy_d;
      lnk.frame_sent <= fs_d;
    end
  end

  // counters, request/reload latches and the payload snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      seq         <= '0;
      reload_flag <= 1'b0;
      pending     <= 1'b0;
      snap_score  <= '0;
      snap_ammo   <= '0;
      snap_seq    <= '0;
      snap_pause  <= 1'b0;
      snap_rel    <= 1'b0;
    end else begin
      baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
      if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      if (pkt_start)                  byte_idx <= 2'd0;
      else if (state == STOP && tick) byte_idx <= byte_idx + 2'd1;
      if (last_stop) seq <= seq + 4'd1;
      reload_flag <= pkt_start ? 1'b0 : (reload_flag | lnk.reload);
      pending     <= pkt_start ? 1'b0 : (pending | lnk.send);
      if (pkt_start) begin
        snap_score <= lnk.score;
        snap_ammo  <= lnk.ammo;
        snap_pause <= lnk.pause;
        snap_rel   <= reload_flag | lnk.reload;
        // back-to-back packet must carry the sequence number after this one
        snap_seq   <= last_stop ? seq + 4'd1 : seq;
      end
    end
  end
endmodule

// File: tb/tb_mp_link_tx.sv
// Bench for mp_link_tx: UART decoder feeds a byte queue compared against
// packets predicted by a small model at stimulus time.
module tb_mp_link_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mp_link_tx_if lnk();

  mp_link_tx #(.CLK_HZ(1000), .BAUD(250)) dut (.clk(clk), .rst(rst), .lnk(lnk.slave));

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         fs_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [3:0] seq_m = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (lnk.frame_sent === 1'b1) fs_cnt <= fs_cnt + 1;

  // line decoder: 4 clocks/bit, samples mid-bit; drops bytes touched by reset or bad framing
  initial begin
    logic [7:0] b;
    bit bad;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && lnk.tx === 1'b0) begin
        bad = 0;
        repeat (2) @(negedge clk);
        if (lnk.tx !== 1'b0 || rst !== 1'b1) bad = 1;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = lnk.tx;
          if (rst !== 1'b1) bad = 1;
        end
        repeat (4) @(negedge clk);
        if (lnk.tx !== 1'b1 || rst !== 1'b1) bad = 1;
        if (!bad) rx_q.push_back(b);
      end
    end
  end

  function automatic void push_pkt(input logic [3:0] sc, input logic [3:0] am,
                                   input logic pa, input logic rl, input logic [3:0] sq);
    logic [7:0] p1, p2;
    p1 = {sc, am};
    p2 = {pa, rl, 2'b00, sq};
    exp_q.push_back(8'hA5);
    exp_q.push_back(p1);
    exp_q.push_back(p2);
    exp_q.push_back(8'hA5 ^ p1 ^ p2);
  endfunction

  task automatic pulse_send();
    @(posedge clk); #1 lnk.send = 1'b1;
    @(posedge clk); #1 lnk.send = 1'b0;
  endtask

  task automatic wait_fs(input int target, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (fs_cnt >= target) begin ok = 1; break; end
    end
  endtask

  task automatic send_pkt(output bit ok);
    int base;
    base = fs_cnt;
    pulse_send();
    wait_fs(base + 1, 400, ok);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    seq_m = 4'd0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    int bad_tx, bad_busy, bad_fs;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (lnk.tx !== 1'b1) begin n_bad++; $display("FAIL rst_tx: got %b want 1", lnk.tx); end
    n_cmp++; if (lnk.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", lnk.busy); end
    n_cmp++; if (lnk.frame_sent !== 1'b0) begin n_bad++; $display("FAIL rst_fs: got %b want 0", lnk.frame_sent); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bad_tx = 0; bad_busy = 0; bad_fs = 0;
    repeat (200) begin
      @(negedge clk);
      if (lnk.tx !== 1'b1) bad_tx++;
      if (lnk.busy !== 1'b0) bad_busy++;
      if (lnk.frame_sent !== 1'b0) bad_fs++;
    end
    n_cmp++; if (bad_tx != 0) begin n_bad++; $display("FAIL idle_tx: %0d cycles low, want 0", bad_tx); end
    n_cmp++; if (bad_busy != 0) begin n_bad++; $display("FAIL idle_busy: %0d cycles busy, want 0", bad_busy); end
    n_cmp++; if (bad_fs != 0) begin n_bad++; $display("FAIL idle_fs: %0d pulses, want 0", bad_fs); end
  endtask

  task automatic test_basic();
    int t0, t1, lim;
    bit ok, busy_at_fs;
    logic [7:0] e, g;
    lnk.score = 4'd3; lnk.ammo = 4'd5; lnk.pause = 1'b1; lnk.reload = 1'b0;
    push_pkt(4'd3, 4'd5, 1'b1, 1'b0, seq_m);
    pulse_send();
    @(negedge clk);
    t0 = cyc;
    n_cmp++; if (lnk.tx !== 1'b0) begin n_bad++; $display("FAIL basic_start: tx %b want 0", lnk.tx); end
    n_cmp++; if (lnk.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", lnk.busy); end
    t1 = -1; lim = 0; busy_at_fs = 1'b1;
    while (t1 < 0 && lim < 400) begin
      @(negedge clk); lim++;
      if (lnk.frame_sent === 1'b1) begin t1 = cyc; busy_at_fs = lnk.busy; end
    end
    n_cmp++; if (t1 - t0 != 160) begin n_bad++; $display("FAIL basic_len: got %0d cycles want 160", t1 - t0); end
    n_cmp++; if (busy_at_fs !== 1'b0) begin n_bad++; $display("FAIL basic_busy_fall: got %b want 0", busy_at_fs); end
    seq_m++;
    repeat (2) @(negedge clk);
    // second packet shows the sequence number has advanced to 1
    push_pkt(4'd3, 4'd5, 1'b1, 1'b0, seq_m);
    send_pkt(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: no frame_sent"); end
    seq_m++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL basic_byte: got none want %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL basic_byte: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_reload();
    int base;
    bit ok;
    logic [7:0] e, g;
    do_reset();
    lnk.score = 4'd3; lnk.ammo = 4'd5; lnk.pause = 1'b1;
    // reload arrives after the snapshot: next packet carries it
    push_pkt(4'd3, 4'd5, 1'b1, 1'b0, 4'd0);
    base = fs_cnt;
    pulse_send();
    repeat (60) @(posedge clk);
    #1 lnk.reload = 1'b1;
    @(posedge clk); #1 lnk.reload = 1'b0;
    wait_fs(base + 1, 400, ok);
    repeat (2) @(negedge clk);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reload_timeout1: no frame_sent"); end
    push_pkt(4'd3, 4'd5, 1'b1, 1'b1, 4'd1);
    send_pkt(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reload_timeout2: no frame_sent"); end
    push_pkt(4'd3, 4'd5, 1'b1, 1'b0, 4'd2);
    send_pkt(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reload_timeout3: no frame_sent"); end
    // reload coincident with send goes straight into that packet
    push_pkt(4'd3, 4'd5, 1'b1, 1'b1, 4'd3);
    base = fs_cnt;
    @(posedge clk); #1 lnk.send = 1'b1; lnk.reload = 1'b1;
    @(posedge clk); #1 lnk.send = 1'b0; lnk.reload = 1'b0;
    wait_fs(base + 1, 400, ok);
    repeat (2) @(negedge clk);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reload_timeout4: no frame_sent"); end
    push_pkt(4'd3, 4'd5, 1'b1, 1'b0, 4'd4);
    send_pkt(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reload_timeout5: no frame_sent"); end
    seq_m = 4'd5;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL reload_byte: got none want %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL reload_byte: got %h want %h", g, e); end end
    end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL reload_extra: %0d extra bytes want 0", rx_q.size()); end
  endtask

  task automatic test_back_to_back();
    int fs_seen, busy_gap, tx_at_fs1, extra, lim;
    logic [7:0] e, g;
    lnk.score = 4'd9; lnk.ammo = 4'd2; lnk.pause = 1'b0; lnk.reload = 1'b0;
    push_pkt(4'd9, 4'd2, 1'b0, 1'b0, seq_m);
    push_pkt(4'd9, 4'd2, 1'b0, 1'b0, seq_m + 4'd1);
    pulse_send();
    fork
      begin
        repeat (20) @(posedge clk); pulse_send();
        repeat (30) @(posedge clk); pulse_send();
        repeat (40) @(posedge clk); pulse_send();
      end
      begin
        fs_seen = 0; busy_gap = 0; tx_at_fs1 = 1; lim = 0;
        while (fs_seen < 2 && lim < 600) begin
          @(negedge clk); lim++;
          if (lnk.frame_sent === 1'b1) begin
            fs_seen++;
            if (fs_seen == 1) begin
              tx_at_fs1 = lnk.tx;
              if (lnk.busy !== 1'b1) busy_gap++;
            end
          end else if (lnk.busy !== 1'b1) busy_gap++;
        end
      end
    join
    n_cmp++; if (fs_seen != 2) begin n_bad++; $display("FAIL b2b_fs: got %0d pulses want 2", fs_seen); end
    n_cmp++; if (busy_gap != 0) begin n_bad++; $display("FAIL b2b_busy: %0d cycles low want 0", busy_gap); end
    n_cmp++; if (tx_at_fs1 != 0) begin n_bad++; $display("FAIL b2b_gap: tx %0d at first frame_sent want 0", tx_at_fs1); end
    extra = 0;
    repeat (200) begin @(negedge clk); if (lnk.frame_sent === 1'b1) extra++; end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL b2b_extra: %0d extra packets want 0", extra); end
    seq_m = seq_m + 4'd2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL b2b_byte: got none want %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL b2b_byte: got %h want %h", g, e); end end
    end
  endtask

  task automatic test_seq_wrap();
    bit ok;
    logic [7:0] e, g;
    logic [7:0] got [4];
    do_reset();
    lnk.pause = 1'b0; lnk.reload = 1'b0;
    for (int i = 0; i < 17; i++) begin
      lnk.score = 4'(i); lnk.ammo = 4'(15 - i);
      push_pkt(4'(i), 4'(15 - i), 1'b0, 1'b0, seq_m);
      seq_m++;
      send_pkt(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout: packet %0d", i); end
    end
    for (int k = 0; k < 17; k++) begin
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front(); n_cmp++;
        g = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        got[j] = g;
        if (g !== e) begin n_bad++; $display("FAIL wrap_byte: pkt %0d byte %0d got %h want %h", k, j, g, e); end
      end
      n_cmp++;
      if (got[3] !== (got[0] ^ got[1] ^ got[2])) begin
        n_bad++; $display("FAIL wrap_xor: pkt %0d got %h want %h", k, got[3], got[0] ^ got[1] ^ got[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e, g;
    lnk.score = 4'd6; lnk.ammo = 4'd7; lnk.pause = 1'b0; lnk.reload = 1'b0;
    pulse_send();
    // first cycle of the packet is now current; B1 data bit 3 spans offsets 56..59
    repeat (57) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (lnk.tx !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tx: got %b want 1", lnk.tx); end
    n_cmp++; if (lnk.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", lnk.busy); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (60) @(posedge clk);
    rx_q.delete(); exp_q.delete();
    seq_m = 4'd0;
    push_pkt(4'd6, 4'd7, 1'b0, 1'b0, seq_m);
    send_pkt(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL mid_timeout: no frame_sent"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (rx_q.size() == 0) begin n_bad++; $display("FAIL mid_byte: got none want %h", e); end
      else begin g = rx_q.pop_front(); if (g !== e) begin n_bad++; $display("FAIL mid_byte: got %h want %h", g, e); end end
    end
  endtask

  initial begin
    lnk.send = 1'b0; lnk.score = '0; lnk.ammo = '0; lnk.pause = 1'b0; lnk.reload = 1'b0;
    test_reset();
    test_basic();
    test_reload();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
